// File: rtl/psum_deskew_collector.sv
`default_nettype none
// ============================================================================
// Module  : psum_deskew_collector
// Brief   : Collects skewed systolic-array partial sums into an N x N buffer
//           and emits deskewed result rows over a valid/ready handshake.
// Revision: 1.0
// ============================================================================
module psum_deskew_collector #(
  parameter int SYSTOLIC_SIZE     = 8,
  parameter int PARTIAL_SUM_WIDTH = 19,
  parameter int CAPTURE_DELAY     = 17
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         start,
  input  logic [SYSTOLIC_SIZE*PARTIAL_SUM_WIDTH-1:0]   partial_sum_flat,
  output logic [SYSTOLIC_SIZE*PARTIAL_SUM_WIDTH-1:0]   row_data,
  output logic [((SYSTOLIC_SIZE > 1) ? $clog2(SYSTOLIC_SIZE) : 1)-1:0] row_idx,
  output logic                                         row_valid,
  input  logic                                         row_ready,
  output logic                                         busy,
  output logic                                         done
);

  localparam int c_n     = SYSTOLIC_SIZE;
  localparam int c_psw   = PARTIAL_SUM_WIDTH;
  localparam int c_idx_w = (c_n > 1) ? $clog2(c_n) : 1;
  localparam int c_ptr_w = $clog2(c_n + 1);
  localparam int c_cnt_w = $clog2(2 * c_n);

  localparam logic [2:0] c_st_idle    = 3'd0;
  localparam logic [2:0] c_st_wait    = 3'd1;
  localparam logic [2:0] c_st_capture = 3'd2;
  localparam logic [2:0] c_st_drain   = 3'd3;
  localparam logic [2:0] c_st_finish  = 3'd4;

  logic [2:0]         r_state;
  logic [2:0]         w_state_next;
  logic [7:0]         r_delay;
  logic [c_cnt_w-1:0] r_cap_cnt;
  logic [c_ptr_w-1:0] r_row_ptr;
  logic [c_ptr_w-1:0] r_complete;
  logic [c_ptr_w-1:0] w_ptr_next;
  logic [c_ptr_w-1:0] w_complete_next;
  logic               r_row_valid;
  logic               w_start_ok;
  logic               w_cap_edge;
  logic               w_last_cap;
  logic               w_fire;
  logic               w_row_done;
  logic               w_valid_next;
  logic [c_idx_w-1:0] w_row_sel;
  logic [c_psw-1:0]   r_buf [c_n][c_n];

  // Capture edge j=0 is the edge on which WAIT sees its counter at zero, so
  // the first capture lands exactly CAPTURE_DELAY edges after start.
  assign w_start_ok      = (r_state == c_st_idle) && start;
  assign w_cap_edge      = (r_state == c_st_capture) ||
                           ((r_state == c_st_wait) && (r_delay == 8'd0));
  assign w_last_cap      = (r_cap_cnt == c_cnt_w'(2 * c_n - 2));
  assign w_fire          = r_row_valid & row_ready;
  assign w_row_done      = w_cap_edge && (r_cap_cnt >= c_cnt_w'(c_n - 1));
  assign w_ptr_next      = r_row_ptr + c_ptr_w'(w_fire);
  assign w_complete_next = r_complete + c_ptr_w'(w_row_done);
  assign w_valid_next    = (w_ptr_next < w_complete_next);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_st_idle: begin
        if (start) w_state_next = c_st_wait;
      end
      c_st_wait: begin
        if (r_delay == 8'd0) w_state_next = w_last_cap ? c_st_drain : c_st_capture;
      end
      c_st_capture: begin
        if (w_last_cap) w_state_next = c_st_drain;
      end
      c_st_drain: begin
        if (w_fire && (r_row_ptr == c_ptr_w'(c_n - 1))) w_state_next = c_st_finish;
      end
      c_st_finish: begin
        w_state_next = c_st_idle;
      end
      default: begin
        w_state_next = c_st_idle;
      end
    endcase
  end

  always_comb begin
    busy = (r_state == c_st_wait) || (r_state == c_st_capture) || (r_state == c_st_drain);
    done = (r_state == c_st_finish);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_delay     <= '0;
      r_cap_cnt   <= '0;
      r_row_ptr   <= '0;
      r_complete  <= '0;
      r_row_valid <= 1'b0;
    end else if (w_start_ok) begin
      r_delay     <= 8'(CAPTURE_DELAY - 1);
      r_cap_cnt   <= '0;
      r_row_ptr   <= '0;
      r_complete  <= '0;
      r_row_valid <= 1'b0;
    end else begin
      if ((r_state == c_st_wait) && (r_delay != 8'd0)) r_delay <= r_delay - 8'd1;
      if (w_cap_edge) r_cap_cnt <= r_cap_cnt + c_cnt_w'(1);
      r_row_ptr   <= w_ptr_next;
      r_complete  <= w_complete_next;
      r_row_valid <= w_valid_next;
    end
  end

  // Lane i carries row i; at capture edge j it holds column j-i of that row.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < c_n; i++) begin
        for (int k = 0; k < c_n; k++) begin
          r_buf[i][k] <= '0;
        end
      end
    end else if (w_cap_edge) begin
      for (int i = 0; i < c_n; i++) begin
        for (int k = 0; k < c_n; k++) begin
          if (r_cap_cnt == c_cnt_w'(i + k)) r_buf[i][k] <= partial_sum_flat[i*c_psw +: c_psw];
        end
      end
    end
  end

  assign w_row_sel = (r_row_ptr < c_ptr_w'(c_n)) ? r_row_ptr[c_idx_w-1:0] : '0;
  assign row_idx   = w_row_sel;
  assign row_valid = r_row_valid;

  for (genvar c = 0; c < c_n; c++) begin : g_col
    assign row_data[c*c_psw +: c_psw] = r_buf[w_row_sel][c];
  end

endmodule
`default_nettype wire

// File: tb/tb_psum_deskew_collector.sv
`default_nettype none
// Directed bench for psum_deskew_collector: skewed lane stimulus, row
// ordering/data/timing checks under several row_ready patterns, and reset abort.
module tb_psum_deskew_collector;

  localparam int N   = 8;
  localparam int PSW = 19;
  localparam int DLY = 17;
  localparam int W   = N * PSW;
  localparam int CW  = W + 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         row_ready = 1'b0;
  logic [W-1:0] partial_sum_flat = '0;
  logic [W-1:0] row_data;
  logic [2:0]   row_idx;
  logic         row_valid;
  logic         busy;
  logic         done;

  psum_deskew_collector #(
    .SYSTOLIC_SIZE    (N),
    .PARTIAL_SUM_WIDTH(PSW),
    .CAPTURE_DELAY    (DLY)
  ) u_dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .partial_sum_flat(partial_sum_flat),
    .row_data        (row_data),
    .row_idx         (row_idx),
    .row_valid       (row_valid),
    .row_ready       (row_ready),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int          n_checks = 0;
  int          n_errors = 0;
  int          base = 0;
  int          rdy_mode = 0;
  int          n_rows = 0;
  int          done_cnt = 0;
  int          done_cyc = -1;
  int          xfer_edge [N];
  int          cap_edge [2*N-1];
  bit          mon_en = 1'b0;
  logic        stall_prev = 1'b0;
  logic [CW-1:0] prev_snap = '0;

  task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] exp_row(input int r);
    logic [W-1:0] v;
    v = '0;
    for (int c = 0; c < N; c++) v[c*PSW +: PSW] = PSW'(base + 100 * r + c);
    return v;
  endfunction

  task automatic drive_lanes(input int j);
    for (int i = 0; i < N; i++) begin
      if ((j - i >= 0) && (j - i < N)) partial_sum_flat[i*PSW +: PSW] = PSW'(base + 100 * i + (j - i));
      else                             partial_sum_flat[i*PSW +: PSW] = 19'h7FFFF;
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    if (rdy_mode == 2) row_ready = ~row_ready;
  endtask

  // Transfers are observed on the negedge before the edge that commits them.
  always @(negedge clk) begin
    if (mon_en) begin
      if (!rst_n) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) check("stall_hold", {4'b0, row_valid, row_idx, row_data}, prev_snap);
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        if (row_valid && row_ready) begin
          if (n_rows < N) begin
            check("row_idx", row_idx, n_rows);
            check("row_data", row_data, exp_row(n_rows));
            xfer_edge[n_rows] = cyc + 1;
          end else begin
            check("extra_row", n_rows + 1, N);
          end
          n_rows++;
        end
        stall_prev = row_valid && !row_ready;
        prev_snap  = {4'b0, row_valid, row_idx, row_data};
      end
    end
  end

  task automatic run(input int b, input int mode, input bit inject);
    int k;
    base = b;
    rdy_mode = mode;
    n_rows = 0;
    done_cnt = 0;
    done_cyc = -1;
    for (int r = 0; r < N; r++) xfer_edge[r] = -1;
    row_ready = (mode == 0);
    check("idle_busy", busy, 0);
    start = 1'b1;
    tick;
    start = 1'b0;
    check("busy_after_start", busy, 1);
    repeat (DLY - 1) tick;
    for (int j = 0; j < 2 * N - 1; j++) begin
      drive_lanes(j);
      if (inject && j == 3) start = 1'b1;
      tick;
      start = 1'b0;
      cap_edge[j] = cyc;
    end
    partial_sum_flat = '1;
    if (mode == 1) begin
      repeat (10) tick;
      check("stall_no_xfer", n_rows, 0);
      check("stall_valid", {row_valid, row_idx}, {1'b1, 3'd0});
      row_ready = 1'b1;
    end
    if (inject) begin
      tick;
      start = 1'b1;
      tick;
      start = 1'b0;
    end
    k = 0;
    while (done_cnt == 0 && k < 300) begin
      tick;
      k++;
    end
    repeat (6) tick;
    check("rows", n_rows, N);
    check("done_cnt", done_cnt, 1);
    check("busy_end", busy, 0);
    check("done_time", done_cyc, xfer_edge[N-1]);
    if (mode == 0) begin
      for (int r = 0; r < N; r++) check("xfer_time", xfer_edge[r], cap_edge[r+N-1] + 1);
    end
    if (mode == 1) begin
      check("xfer_first", xfer_edge[0], cap_edge[2*N-2] + 11);
      for (int r = 1; r < N; r++) check("xfer_consec", xfer_edge[r], xfer_edge[0] + r);
    end
    rdy_mode = 0;
    row_ready = 1'b0;
  endtask

  task automatic abort_run;
    base = 0;
    rdy_mode = 0;
    n_rows = 0;
    done_cnt = 0;
    row_ready = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (DLY - 1) tick;
    for (int j = 0; j < 5; j++) begin
      drive_lanes(j);
      tick;
    end
    drive_lanes(5);
    rst_n = 1'b0;
    tick;
    check("abort_valid", row_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_idx", row_idx, 0);
    check("abort_data", row_data, 0);
    tick;
    rst_n = 1'b1;
    partial_sum_flat = '1;
    repeat (20) tick;
    check("abort_no_done", done_cnt, 0);
    check("abort_no_rows", n_rows, 0);
    check("abort_idle", busy, 0);
    row_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) tick;
    check("rst_valid", row_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_idx", row_idx, 0);
    check("rst_data", row_data, 0);
    rst_n = 1'b1;
    tick;
    mon_en = 1'b1;

    run(0, 0, 1'b0);
    run(0, 1, 1'b0);
    run(0, 2, 1'b0);
    run(0, 0, 1'b1);
    abort_run();
    run(1000, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
